// File: rtl/clk_div_prog.sv
// ============================================================================
//  Module      : clk_div_prog
//  Description : Runtime-programmable clock divider / tick generator with
//                toggle (50 % square wave) and pulse (strobe) output modes.
//                Divisor/mode changes take effect only at period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_RESET = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_div_reset = WIDTH'(DIV_RESET);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic [WIDTH-1:0] r_sh_div;
    logic             r_sh_mode;
    logic             r_pending;
    logic             r_out;
    logic             r_tick;
    logic             r_ack;

    logic [WIDTH-1:0] w_div_cap;
    logic             w_terminal;
    logic             w_apply;
    logic [WIDTH-1:0] w_apply_div;
    logic             w_apply_mode;
    logic             w_next_mode;

    // A zero divisor would never reach a terminal count, so it is clamped.
    assign w_div_cap    = (div_in == '0) ? c_one : div_in;
    assign w_terminal   = (r_cnt == (r_div - c_one));

    // A load arriving this cycle bypasses (and supersedes) the shadow copy.
    assign w_apply      = div_load | r_pending;
    assign w_apply_div  = div_load ? w_div_cap : r_sh_div;
    assign w_apply_mode = div_load ? mode      : r_sh_mode;
    assign w_next_mode  = w_apply  ? w_apply_mode : r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= c_div_reset;
            r_mode    <= 1'b0;
            r_sh_div  <= c_div_reset;
            r_sh_mode <= 1'b0;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            if (en) begin
                if (w_terminal) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    if (w_apply) begin
                        r_div     <= w_apply_div;
                        r_mode    <= w_apply_mode;
                        r_pending <= 1'b0;
                        r_ack     <= 1'b1;
                    end
                    // Pulse mode strobes high; leaving pulse mode starts the
                    // first square-wave half-period high.
                    if (w_next_mode || r_mode) begin
                        r_out <= 1'b1;
                    end else begin
                        r_out <= ~r_out;
                    end
                end else begin
                    r_cnt <= r_cnt + c_one;
                    if (r_mode) begin
                        r_out <= 1'b0;
                    end
                    if (div_load) begin
                        r_sh_div  <= w_div_cap;
                        r_sh_mode <= mode;
                        r_pending <= 1'b1;
                    end
                end
            end else if (w_apply) begin
                // No period is running while disabled, so apply at once.
                r_cnt     <= '0;
                r_div     <= w_apply_div;
                r_mode    <= w_apply_mode;
                r_pending <= 1'b0;
                r_ack     <= 1'b1;
                if (w_apply_mode) begin
                    r_out <= 1'b0;
                end
            end
        end
    end

    assign out     = r_out;
    assign tick    = r_tick;
    assign div_ack = r_ack;

endmodule

`default_nettype wire

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider and tick generator.
- Divides `clk` by a divisor loaded at run time.
- Has two output modes: a 50 % square wave (toggle) or a one-cycle strobe (pulse).
- A new divisor or mode is applied only at a period boundary, so no runt periods are produced.
- Sits between the system clock and slow peripherals (display scan, debouncers, LED blink); replaces the fixed-divisor divider in new designs.

## Interface
Parameters:
- `WIDTH`, 32: width of the divisor and of the internal counter.
- `DIV_RESET`, 50_000_000: active divisor after reset. Must be in 1..2^WIDTH-1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: count enable.
- `mode` input 1: 0 = toggle (square wave), 1 = pulse (strobe).
- `div_in` input WIDTH: requested divisor D.
- `div_load` input 1: one-cycle request to capture `div_in` and `mode`.
- `div_ack` output 1: one-cycle pulse when a request has been applied.
- `out` output 1: divided clock (toggle mode) or strobe (pulse mode).
- `tick` output 1: one-cycle strobe every D enabled cycles, in both modes.

## Operation
Internal state:
- Active divisor `D`, active mode `M`.
- Counter `cnt` (WIDTH bits).
- Shadow divisor and shadow mode, plus a `pending` flag.

Reset (`rst`=1 at a clock edge): `cnt`=0, `D`=DIV_RESET, `M`=0, `pending`=0, `out`=0, `tick`=0, `div_ack`=0.

Counting (`en`=1):
- Terminal event (`cnt`==D-1): `cnt`←0 and `tick`←1.
  - If M=0: `out`←~`out`.
  - If M=1: `out`←1.
- Otherwise: `cnt`←`cnt`+1, `tick`←0, and `out`←0 if M=1 (hold if M=0).

Disabled (`en`=0):
- `cnt`, `D`, `M` and `out` hold; `tick`←0.
- Exception: if `pending`=1 (or `div_load`=1 this cycle), apply the request immediately: load `D`/`M`, `cnt`←0, pulse `div_ack`.
- In that case `out`←0 if the new M=1; otherwise `out` holds.

Load requests:
- `div_load`=1 writes the shadow registers and sets `pending`.
- A second load while pending overwrites the shadow; only one `div_ack` is produced.
- Applied at the next terminal event: `D`←shadow D, `M`←shadow M, `pending`←0, `div_ack`←1 for one cycle.
- `div_load` in the same cycle as a terminal event bypasses the shadow: `div_in`/`mode` take effect at that boundary.
- On a mode change 1→0 at a boundary, `out`←1: the first toggle-mode half-period starts high.

Width and range rules:
- `div_in`=0 is clamped to 1 on capture.
- D=1, M=0: `out` toggles every enabled cycle (clk/2).
- D=1, M=1: `out`=`tick`=1 continuously while enabled.
- `cnt` never exceeds D-1. No overflow path exists: D ≤ 2^WIDTH-1.

## Timing
- All outputs are registered; none are combinational from inputs.
- First `tick` after reset: D enabled rising edges after the first edge with `en`=1.
- `tick` period: D enabled cycles.
- `out` period: 2·D cycles in toggle mode, high for exactly D; D cycles in pulse mode, high for 1.
- `div_ack` rises on the same edge as the `tick` of the boundary where the request was applied. While disabled, it rises 1 cycle after `div_load`.
- New D governs the period that starts at the applying boundary. The old period always completes in full.
- `rst` mid-period discards any pending request with no `div_ack`; outputs are 0 on the next cycle.
- `en` deassertion freezes the phase; reassertion resumes from the held `cnt`.

## Test plan
- Reset default with DIV_RESET=4, `en`=1, M=0: `tick` every 4 cycles; `out` 4 high / 4 low; `div_ack` never asserted.
- Pulse mode: load D=3, M=1 while enabled. `div_ack` coincides with the next boundary tick; afterwards `out`==`tick`, high 1 of every 3 cycles.
- Mid-period load: D=5, load D=2 at `cnt`=1. The current 5-cycle period completes, then ticks every 2. Load D=7 then D=9 within one period: single `div_ack`, D=9 applied.
- Boundary/edge values:
  - Load coincident with terminal event: new D effective at that boundary.
  - `div_in`=0: behaves as D=1 (toggle every cycle).
  - D=1, M=1: `out` stays high.
- Disable and reset:
  - `en`=0 at `cnt`=2 for 10 cycles: outputs frozen, `tick`=0; resumes with `tick` D-2 cycles after reassertion.
  - Load while disabled: `div_ack` next cycle, `cnt`=0.
  - `rst` pulse with a pending load: all outputs 0, D=DIV_RESET, no ack.
